// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the rr_arbiter block: arbitration policy,
// output-stage state and the pointer width helper.
package rr_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // A pointer must be at least one bit wide even for degenerate channel counts.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational winner selection: fixed lowest-index priority, or round-robin
// starting just after the last winner held in ptr.
module rr_arbiter_pick
    import rr_arbiter_pkg::*;
#(
    parameter int        N    = 3,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       PW   = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    // Round-robin scans offsets 1..N past ptr so the last winner is checked last.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        if (MODE == ARB_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                        gnt[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-channel arbiter feeding a single-entry output register; a new word is
// accepted whenever the register is empty or being consumed this cycle.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int        WIDTH = 64,
    parameter int        N     = 3,
    parameter arb_mode_e MODE  = ARB_RR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic [N-1:0]       result_unit,
    input  logic               result_ack
);

    localparam int PW = ptr_width(N);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [N-1:0]     unit_q, unit_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic             load;
    logic [N-1:0]     gnt;
    logic [WIDTH-1:0] win_data;
    logic [PW-1:0]    win_idx;

    rr_arbiter_pick #(
        .N    (N),
        .MODE (MODE)
    ) u_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        load = (|in_valid) && ((state_q == OUT_EMPTY) || result_ack);
    end

    // gnt is one-hot, so OR-ing the selected slices gives a plain mux.
    always_comb begin
        win_data = '0;
        win_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win_data = win_data | in_data[i*WIDTH +: WIDTH];
                win_idx  = PW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        unit_d   = unit_q;
        ptr_d    = ptr_q;
        case (state_q)
            OUT_EMPTY: begin
                if (load) begin
                    state_d  = OUT_FULL;
                    result_d = win_data;
                    unit_d   = gnt;
                    if (MODE == ARB_RR) ptr_d = win_idx;
                end
            end
            OUT_FULL: begin
                if (load) begin
                    result_d = win_data;
                    unit_d   = gnt;
                    if (MODE == ARB_RR) ptr_d = win_idx;
                end else if (result_ack) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // Reset points ptr at the last channel so channel 0 wins the first round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OUT_EMPTY;
            result_q <= '0;
            unit_q   <= '0;
            ptr_q    <= PW'(N - 1);
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            unit_q   <= unit_d;
            ptr_q    <= ptr_d;
        end
    end

    // Grants are suppressed while reset is held even though the stage looks empty.
    assign in_ready     = (rst_n && load) ? gnt : '0;
    assign result       = result_q;
    assign result_valid = (state_q == OUT_FULL);
    assign result_unit  = unit_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Drives a round-robin and a fixed-priority rr_arbiter with shared stimulus and
// compares both against a behavioural model of the arbitration rules.
module tb_rr_arbiter;
    import rr_arbiter_pkg::*;

    localparam int N = 3;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic             result_ack;

    logic [N-1:0]     rdy_rr, rdy_fx, unit_rr, unit_fx;
    logic [W-1:0]     res_rr, res_fx;
    logic             val_rr, val_fx;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit           full;
        logic [W-1:0] data;
        int           unit;
        int           last;
    } model_t;

    model_t m_rr, m_fx;

    always #5 clk = ~clk;

    rr_arbiter #(.WIDTH(W), .N(N), .MODE(ARB_RR)) dut_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (rdy_rr),
        .result       (res_rr),
        .result_valid (val_rr),
        .result_unit  (unit_rr),
        .result_ack   (result_ack)
    );

    rr_arbiter #(.WIDTH(W), .N(N), .MODE(ARB_FIXED)) dut_fx (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (rdy_fx),
        .result       (res_fx),
        .result_valid (val_fx),
        .result_unit  (unit_fx),
        .result_ack   (result_ack)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Round-robin: channels above the last winner get first chance, then from 0.
    function automatic int pickWinner(input bit rr, input int last, input logic [N-1:0] v);
        if (rr) begin
            for (int i = last + 1; i < N; i++) if (v[i]) return i;
        end
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        return (w < 0) ? '0 : (N'(1) << w);
    endfunction

    function automatic model_t modelReset();
        model_t m;
        m.full = 1'b0;
        m.data = '0;
        m.unit = -1;
        m.last = N - 1;
        return m;
    endfunction

    function automatic model_t modelStep(input model_t m, input bit rr, input logic [N-1:0] v,
                                         input logic ack, input logic [N*W-1:0] d);
        model_t n = m;
        int w = pickWinner(rr, m.last, v);
        if (w >= 0 && (!m.full || ack)) begin
            n.full = 1'b1;
            n.data = d[w*W +: W];
            n.unit = w;
            if (rr) n.last = w;
        end else if (m.full && ack) begin
            n.full = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [N-1:0] modelReady(input model_t m, input bit rr, input logic [N-1:0] v, input logic ack);
        if (!(|v) || (m.full && !ack)) return '0;
        return onehot(pickWinner(rr, m.last, v));
    endfunction

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_rr_valid"}, W'(val_rr), W'(m_rr.full));
        checkOutput({tag, "_rr_unit"}, W'(unit_rr), W'(onehot(m_rr.unit)));
        checkOutput({tag, "_rr_data"}, res_rr, m_rr.data);
        checkOutput({tag, "_fx_valid"}, W'(val_fx), W'(m_fx.full));
        checkOutput({tag, "_fx_unit"}, W'(unit_fx), W'(onehot(m_fx.unit)));
        checkOutput({tag, "_fx_data"}, res_fx, m_fx.data);
    endtask

    // One cycle: drive inputs, check the combinational grant, then the registered result.
    task automatic applyStimulus(input logic [N-1:0] v, input logic ack, input bit rand_data);
        model_t n_rr, n_fx;
        in_valid   = v;
        result_ack = ack;
        if (rand_data) begin
            for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};
        end
        #1;
        checkOutput("ready_rr", W'(rdy_rr), W'(modelReady(m_rr, 1'b1, v, ack)));
        checkOutput("ready_fx", W'(rdy_fx), W'(modelReady(m_fx, 1'b0, v, ack)));
        n_rr = modelStep(m_rr, 1'b1, v, ack, in_data);
        n_fx = modelStep(m_fx, 1'b0, v, ack, in_data);
        @(posedge clk);
        m_rr = n_rr;
        m_fx = n_fx;
        @(negedge clk);
        checkRegs("cycle");
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        in_valid = '1;
        #1;
        m_rr = modelReset();
        m_fx = modelReset();
        checkRegs("reset");
        checkOutput("reset_ready_rr", W'(rdy_rr), '0);
        checkOutput("reset_ready_fx", W'(rdy_fx), '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] seq_exp [4];
        rst_n      = 1'b0;
        in_valid   = '0;
        result_ack = 1'b0;
        in_data    = '0;
        m_rr = modelReset();
        m_fx = modelReset();
        @(negedge clk);
        doReset();

        // Round-robin rotation with everyone requesting
        seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int c = 0; c < 4; c++) begin
            applyStimulus(3'b111, 1'b1, 1'b1);
            checkOutput("rot_unit", W'(unit_rr), W'(seq_exp[c]));
            checkOutput("rot_valid", W'(val_rr), W'(1));
            checkOutput("fixed_all_unit", W'(unit_fx), W'(3'b001));
        end

        for (int c = 0; c < 4; c++) begin
            applyStimulus(3'b110, 1'b1, 1'b1);
            checkOutput("fixed_110_unit", W'(unit_fx), W'(3'b010));
        end

        // Backpressure holds the word and blocks all grants
        doReset();
        in_data[W-1:0] = 64'hA5;
        applyStimulus(3'b111, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(3'b111, 1'b0, 1'b1);
            checkOutput("hold_data", res_rr, 64'hA5);
            checkOutput("hold_ready", W'(rdy_rr), '0);
        end
        applyStimulus(3'b111, 1'b1, 1'b1);
        checkOutput("after_hold_unit", W'(unit_rr), W'(3'b010));

        // Wrap past channel 0 from the reset pointer, then continue after ch1
        doReset();
        applyStimulus(3'b010, 1'b1, 1'b1);
        checkOutput("wrap_unit", W'(unit_rr), W'(3'b010));
        applyStimulus(3'b101, 1'b1, 1'b1);
        checkOutput("after_wrap_unit", W'(unit_rr), W'(3'b100));

        // Drain to empty, then an ack while empty must change nothing
        applyStimulus(3'b000, 1'b1, 1'b1);
        checkOutput("drain_valid", W'(val_rr), '0);
        checkOutput("drain_unit_kept", W'(unit_rr), W'(3'b100));
        applyStimulus(3'b000, 1'b1, 1'b1);
        checkOutput("empty_ack_valid", W'(val_rr), '0);

        // Asynchronous reset mid-transfer
        applyStimulus(3'b100, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", W'(val_rr), '0);
        m_rr = modelReset();
        m_fx = modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'b111, 1'b1, 1'b1);
        checkOutput("post_reset_unit", W'(unit_rr), W'(3'b001));

        // Random traffic with occasional reset pulses
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) == 0) doReset();
            else applyStimulus(N'($urandom), ($urandom_range(3) != 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits per channel.
REQ-002 Parameter N, default 3, channel count; legal range 2..16.
REQ-003 Parameter MODE, default ARB_RR, arbitration policy: ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
REQ-004 Port clk  input  1  single clock; all state on its rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 Port in_data  input  N*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid  input  N  channel i holds a request.
REQ-008 Port in_ready  output  N  channel i payload accepted this cycle.
REQ-009 Port result  output  WIDTH  registered payload of the current winner.
REQ-010 Port result_valid  output  1  result holds an unconsumed word.
REQ-011 Port result_unit  output  N  one-hot index of the channel that supplied result.
REQ-012 Port result_ack  input  1  consumer takes result this cycle when result_valid=1.

Function
REQ-013 The output stage SHALL be one register deep, state EMPTY (result_valid=0) or FULL (result_valid=1).
REQ-014 load = (|in_valid) & (EMPTY | result_ack); load SHALL be computed combinationally each cycle.
REQ-015 On load, the winner w SHALL come from in_valid per MODE, in_ready SHALL equal onehot(w), and at the clock edge result<=in_data[w], result_unit<=onehot(w), result_valid<=1.
REQ-016 Without load, in_ready SHALL be all zeros.
REQ-017 in_ready SHALL never have more than one bit set and SHALL never be set for a channel whose in_valid=0.
REQ-018 FULL with result_ack=1 and no in_valid SHALL go EMPTY (result_valid<=0); result and result_unit hold their last values.
REQ-019 FULL with result_ack=0 SHALL hold result, result_unit and result_valid unchanged regardless of in_valid.
REQ-020 FULL with result_ack=1 and any in_valid SHALL reload in the same cycle, giving one word per cycle with no bubble.
REQ-021 result_ack while EMPTY SHALL be ignored.
REQ-022 Latency SHALL be one cycle from the accepting in_ready to result_valid.
REQ-023 ARB_FIXED: w SHALL be the lowest index with in_valid set.
REQ-024 ARB_RR: a pointer ptr (log2 N bits) SHALL hold last winner. w SHALL be the first set in_valid scanning ptr+1, ptr+2, ... modulo N, wrapping N-1 to 0.
REQ-025 ptr SHALL update to w only on load. In ARB_FIXED ptr SHALL stay unused and constant.
REQ-026 With all N channels continuously valid and result_ack=1 every cycle, ARB_RR SHALL grant each channel exactly once per N consecutive loads.
REQ-027 A channel that drops in_valid while not granted SHALL lose nothing: no capture and no pointer change.

Reset
REQ-028 While rst_n=0: result_valid=0, result=0, result_unit=0, ptr=N-1 (so channel 0 wins first), and in_ready=0.
REQ-029 Reset asserted mid-transfer SHALL discard the held word. The first load after release SHALL follow REQ-023/024 from the reset pointer.

Structure
REQ-030 Package rr_arbiter_pkg SHALL hold the arb_mode_e enum (ARB_FIXED, ARB_RR) and a clog2-based width helper for ptr.
REQ-031 Sub-module rr_arbiter_pick (combinational, parameters N and MODE, inputs req and ptr, output one-hot gnt) SHALL implement REQ-023/024.
REQ-032 rr_arbiter SHALL contain only the output register, ptr and the load logic.

Verification
REQ-033 Reset then in_valid=3'b111, RR, ack=1 every cycle -> result_unit sequence 001, 010, 100, 001; result_valid=1 from cycle 1.
REQ-034 FIXED, in_valid=3'b110 held, ack=1 -> result_unit=010 every cycle; channel 2 is never granted.
REQ-035 RR, load ch0 word 0xA5, ack=0 for 5 cycles while in_valid=3'b111 -> result=0xA5 held, in_ready=000 throughout; first ack then yields ch1 next cycle.
REQ-036 RR, ptr=2, only in_valid[1]=1 -> ch1 wins (wrap past ch0); ptr becomes 1.
REQ-037 FULL, ack=1, in_valid=0 -> result_valid=0 next cycle; a later ack while EMPTY changes nothing.
REQ-038 rst_n pulsed low while FULL -> result_valid=0 immediately (async); next grant is ch0 with in_valid=3'b111.
